alu_req_scheduler: RTL and testbench

- Shares one ALU datapath between NUM_REQ independent requesters. The ALU performs PARITY, POPCOUNT, ROTR and ROTL with fixed pipeline latency.
- Arbitrates round-robin and latches the winner's opcode and operands. Holds them on the ALU inputs for the ALU latency, captures the result, then returns it on a shared tagged response bus.
- Sits between the requesting engines and the ALU top level. Exactly one operation is in flight at a time.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/alu_req_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_alu_req_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU request scheduler: ALU opcode encodings,
// the legal-opcode check and the scheduler FSM state encoding.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] OP_PARITY   = 3'd0;
   localparam logic [2:0] OP_POPCOUNT = 3'd1;
   localparam logic [2:0] OP_ROTR     = 3'd2;
   localparam logic [2:0] OP_ROTL     = 3'd3;
   localparam logic [2:0] OP_NOP      = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } sched_state_e;

   // Opcodes 0..3 are executable; anything with the top bit set is not.
   function automatic logic is_legal_op(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the winner is the first asserted request
// at or after the priority pointer, wrapping around.
//   req_i   : request levels
//   ptr_i   : index with highest priority this evaluation
//   gnt_o   : one-hot winner (all zero when nothing requests)
//   idx_o   : binary index of the winner
//   valid_o : at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               valid_o
);

   // Scan candidates in priority order; the first hit wins, later ones are masked.
   always_comb begin
      logic [ID_W-1:0] cand_s;
      logic            take_s;
      gnt_o   = {NUM_REQ{1'b0}};
      idx_o   = {ID_W{1'b0}};
      valid_o = 1'b0;
      cand_s  = {ID_W{1'b0}};
      take_s  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s          = ID_W'((int'(ptr_i) + k) % NUM_REQ);
         take_s          = !valid_o && req_i[cand_s];
         gnt_o[cand_s]   = gnt_o[cand_s] | take_s;
         idx_o           = take_s ? cand_s : idx_o;
         valid_o         = valid_o | take_s;
      end
   end

endmodule

// File: rtl/alu_req_scheduler.sv
// ---------------------------------------------------------------------------
// alu_req_scheduler
// Shares one fixed-latency ALU between NUM_REQ requesters. A round-robin
// winner's opcode/operands are captured, held on the ALU inputs for the ALU
// latency, and the result is returned on a tagged response bus. One
// operation is in flight at a time; every output is registered.
//   clk, rst                     : clock, synchronous active-high reset
//   req/req_opcode/req_a/req_b   : per-requester request level and payload
//   gnt                          : one-cycle one-hot grant (payload captured)
//   alu_opcode/alu_a/alu_b       : ALU inputs (opcode NOP when idle)
//   alu_result                   : ALU output
//   rsp_valid/rsp_id/rsp_data/rsp_err : tagged response, valid for one cycle
//   busy                         : scheduler not in IDLE
// ---------------------------------------------------------------------------
module alu_req_scheduler
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 1024,
   parameter int NUM_REQ     = 4,
   parameter int ALU_LATENCY = 3,
   parameter int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*3-1:0]          req_opcode,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [2:0]                    alu_opcode,
   output logic [DATA_WIDTH-1:0]         alu_a,
   output logic [DATA_WIDTH-1:0]         alu_b,
   input  logic [DATA_WIDTH-1:0]         alu_result,
   output logic                          rsp_valid,
   output logic [ID_W-1:0]               rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          rsp_err,
   output logic                          busy
);

   localparam int              CNT_W    = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [ID_W-1:0]  ID_ZERO  = ID_W'(0);
   localparam logic [ID_W-1:0]  ID_ONE   = ID_W'(1);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

   sched_state_e          state_q, state_d;
   logic [ID_W-1:0]       ptr_q, ptr_d;
   logic [ID_W-1:0]       id_q, id_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_REQ-1:0]    gnt_q, gnt_d;
   logic [2:0]            alu_opcode_q, alu_opcode_d;
   logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
   logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  busy_q, busy_d;

   logic [NUM_REQ-1:0]    arb_gnt_s;
   logic [ID_W-1:0]       arb_idx_s;
   logic                  arb_valid_s;
   logic [2:0]            sel_op_s;
   logic [DATA_WIDTH-1:0] sel_a_s;
   logic [DATA_WIDTH-1:0] sel_b_s;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt_s),
      .idx_o   (arb_idx_s),
      .valid_o (arb_valid_s)
   );

   // AND-OR mux of the winner's payload, steered by the one-hot grant.
   always_comb begin
      sel_op_s = 3'b000;
      sel_a_s  = {DATA_WIDTH{1'b0}};
      sel_b_s  = {DATA_WIDTH{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         sel_op_s = sel_op_s | (req_opcode[3*k +: 3] & {3{arb_gnt_s[k]}});
         sel_a_s  = sel_a_s  | (req_a[DATA_WIDTH*k +: DATA_WIDTH] & {DATA_WIDTH{arb_gnt_s[k]}});
         sel_b_s  = sel_b_s  | (req_b[DATA_WIDTH*k +: DATA_WIDTH] & {DATA_WIDTH{arb_gnt_s[k]}});
      end
   end

   // Next-state and registered-output logic of the scheduler FSM.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      id_d         = id_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      gnt_d        = {NUM_REQ{1'b0}};
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rsp_valid_d  = 1'b0;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      busy_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            alu_opcode_d = OP_NOP;
            if (arb_valid_s) begin
               gnt_d = arb_gnt_s;
               id_d  = arb_idx_s;
               ptr_d = (arb_idx_s == ID_LAST) ? ID_ZERO : (arb_idx_s + ID_ONE);
               if (is_legal_op(sel_op_s)) begin
                  // The ALU input registers double as the operand latch,
                  // so the ALU sees stable inputs from the ISSUE cycle on.
                  err_d        = 1'b0;
                  alu_opcode_d = sel_op_s;
                  alu_a_d      = sel_a_s;
                  alu_b_d      = sel_b_s;
                  state_d      = ST_ISSUE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == CNT_ZERO) begin
               // Result is registered on entry to RESP so rsp_valid is high during RESP.
               alu_opcode_d = OP_NOP;
               rsp_valid_d  = 1'b1;
               rsp_id_d     = id_q;
               rsp_data_d   = alu_result;
               rsp_err_d    = 1'b0;
               state_d      = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            if (err_q) begin
               // An illegal op enters RESP straight from IDLE with nothing
               // to capture; its error response is registered on leaving RESP.
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_data_d  = {DATA_WIDTH{1'b0}};
               rsp_err_d   = 1'b1;
            end else begin
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ptr_q        <= ID_ZERO;
         id_q         <= ID_ZERO;
         err_q        <= 1'b0;
         cnt_q        <= CNT_ZERO;
         gnt_q        <= {NUM_REQ{1'b0}};
         alu_opcode_q <= OP_NOP;
         alu_a_q      <= {DATA_WIDTH{1'b0}};
         alu_b_q      <= {DATA_WIDTH{1'b0}};
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= ID_ZERO;
         rsp_data_q   <= {DATA_WIDTH{1'b0}};
         rsp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         id_q         <= id_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         gnt_q        <= gnt_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         busy_q       <= busy_d;
      end
   end

   assign gnt        = gnt_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_req_scheduler
// Scoreboard bench: a transaction-level model decides, at each clock edge,
// whether the scheduler is free and which requester wins; it queues the
// expected grant and response (with their cycle numbers). A monitor on the
// falling edge pops and compares whenever the DUT presents gnt / rsp_valid.
// A behavioural 3-stage ALU is attached to the DUT's ALU ports.
// ---------------------------------------------------------------------------
module tb_alu_req_scheduler;
   import alu_pkg::*;

   localparam int DW  = 8;
   localparam int NR  = 4;
   localparam int LAT = 3;
   localparam int IW  = 2;

   logic              clk;
   logic              rst;
   logic [NR-1:0]     req;
   logic [NR*3-1:0]   req_opcode;
   logic [NR*DW-1:0]  req_a;
   logic [NR*DW-1:0]  req_b;
   logic [NR-1:0]     gnt;
   logic [2:0]        alu_opcode;
   logic [DW-1:0]     alu_a;
   logic [DW-1:0]     alu_b;
   logic [DW-1:0]     alu_result;
   logic              rsp_valid;
   logic [IW-1:0]     rsp_id;
   logic [DW-1:0]     rsp_data;
   logic              rsp_err;
   logic              busy;

   alu_req_scheduler #(
      .DATA_WIDTH  (DW),
      .NUM_REQ     (NR),
      .ALU_LATENCY (LAT),
      .ID_W        (IW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_opcode (req_opcode),
      .req_a      (req_a),
      .req_b      (req_b),
      .gnt        (gnt),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural ALU operation: arithmetic straight from the opcode meaning.
   function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      logic [2*DW-1:0] dbl;
      int s;
      int ones;
      dbl  = {a, a};
      s    = int'(b) % DW;
      ones = 0;
      for (int i = 0; i < DW; i++) ones += int'(a[i]);
      case (op)
         3'd0:    return DW'(ones % 2);
         3'd1:    return DW'(ones);
         3'd2:    begin dbl = dbl >> s; return dbl[DW-1:0]; end
         3'd3:    begin dbl = dbl << s; return dbl[2*DW-1:DW]; end
         default: return {DW{1'b0}};
      endcase
   endfunction

   // ALU with LAT-edge latency from stable inputs to valid output.
   logic [DW-1:0] alu_pipe [LAT];
   always @(posedge clk) begin
      alu_pipe[0] <= ref_alu(alu_opcode, alu_a, alu_b);
      for (int k = 1; k < LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
   end
   assign alu_result = alu_pipe[LAT-1];

   typedef struct { logic [NR-1:0] vec; int due; } gexp_t;
   typedef struct { int id; logic [DW-1:0] data; logic err; int due; } rexp_t;
   gexp_t gq[$];
   rexp_t rq[$];

   // Requester-side state and scheduler model.
   bit            r_req [NR];
   logic [2:0]    r_op  [NR];
   logic [DW-1:0] r_a   [NR];
   logic [DW-1:0] r_b   [NR];
   int            ptr_m     = 0;
   int            free_edge = 0;
   int            last_win  = -1;
   int            hold_mask = 0;

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req[i]                = r_req[i];
         req_opcode[3*i +: 3]  = r_op[i];
         req_a[DW*i +: DW]     = r_a[i];
         req_b[DW*i +: DW]     = r_b[i];
      end
   endtask

   function automatic bit any_req();
      bit r;
      r = 1'b0;
      for (int i = 0; i < NR; i++) r = r | r_req[i];
      return r;
   endfunction

   // One clock: apply requests, then model what the scheduler did at that edge.
   task automatic step();
      int e;
      int w;
      int c;
      bit legal;
      gexp_t g;
      rexp_t r;
      drive();
      @(posedge clk);
      #1;
      e        = cyc;
      last_win = -1;
      if (rst) begin
         gq.delete();
         rq.delete();
         ptr_m     = 0;
         free_edge = e + 1;
      end else if (e >= free_edge) begin
         w = -1;
         for (int k = 0; k < NR; k++) begin
            c = (ptr_m + k) % NR;
            if (w < 0 && r_req[c]) w = c;
         end
         if (w >= 0) begin
            legal  = (r_op[w] <= 3'd3);
            g.vec  = '0;
            g.vec[w] = 1'b1;
            g.due  = e;
            gq.push_back(g);
            r.id   = w;
            r.err  = !legal;
            r.data = legal ? ref_alu(r_op[w], r_a[w], r_b[w]) : {DW{1'b0}};
            r.due  = legal ? e + LAT + 1 : e + 1;
            rq.push_back(r);
            free_edge = legal ? e + LAT + 3 : e + 2;
            ptr_m     = (w + 1) % NR;
            last_win  = w;
            r_req[w]  = hold_mask[w];
         end
      end
   endtask

   task automatic run_until_idle(input string name, input int max_steps);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while ((any_req() || cyc < free_edge) && n < max_steps);
      if (any_req() || cyc < free_edge) begin
         total++;
         bad++;
         $display("FAIL timeout_%s: idle=0 required idle=1 after %0d cycles", name, n);
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b);
      r_req[i] = 1'b1;
      r_op[i]  = op;
      r_a[i]   = a;
      r_b[i]   = b;
   endtask

   task automatic new_rand_req(input int i);
      logic [2:0] op;
      op = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      set_req(i, op, DW'($urandom), DW'($urandom));
   endtask

   // Monitor: compare presented grants/responses against the queued expectations.
   always @(negedge clk) begin
      gexp_t g;
      rexp_t r;
      if (!rst) begin
         if (gnt != '0) begin
            if (gq.size() == 0) begin
               chk("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
               g = gq.pop_front();
               chk("gnt_vec", 32'(gnt), 32'(g.vec));
               chk("gnt_cycle", cyc, g.due);
            end
         end else if (gq.size() != 0 && gq[0].due < cyc) begin
            g = gq.pop_front();
            chk("gnt_missing", 32'd0, 32'(g.vec));
         end
         if (rsp_valid) begin
            if (rq.size() == 0) begin
               chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               r = rq.pop_front();
               chk("rsp_id", 32'(rsp_id), r.id);
               chk("rsp_data", 32'(rsp_data), 32'(r.data));
               chk("rsp_err", 32'(rsp_err), 32'(r.err));
               chk("rsp_cycle", cyc, r.due);
            end
         end else if (rq.size() != 0 && rq[0].due < cyc) begin
            r = rq.pop_front();
            chk("rsp_missing", 32'd0, 32'd1);
         end
         if (!busy) chk("idle_alu_nop", 32'(alu_opcode), 32'(OP_NOP));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: finished=0 required finished=1");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int grants;
      int n;
      rst = 1'b1;
      for (int i = 0; i < NR; i++) begin
         r_req[i] = 1'b0;
         r_op[i]  = OP_NOP;
         r_a[i]   = '0;
         r_b[i]   = '0;
      end
      repeat (3) step();
      @(negedge clk);
      chk("reset_gnt", 32'(gnt), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
      chk("reset_rsp_id", 32'(rsp_id), 32'd0);
      chk("reset_rsp_data", 32'(rsp_data), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_alu_opcode", 32'(alu_opcode), 32'(OP_NOP));
      chk("reset_alu_a", 32'(alu_a), 32'd0);
      chk("reset_alu_b", 32'(alu_b), 32'd0);
      rst = 1'b0;

      // Contention from reset: 1,2,3 in order, 0 never asks.
      set_req(1, OP_POPCOUNT, 8'hA5, 8'h00);
      set_req(2, OP_ROTL,     8'h3C, 8'h02);
      set_req(3, OP_PARITY,   8'h01, 8'h00);
      run_until_idle("contention", 60);

      // Fairness: 0 and 1 held high, expect alternation.
      hold_mask = 3;
      set_req(0, OP_ROTR,     8'h12, 8'h03);
      set_req(1, OP_POPCOUNT, 8'hFF, 8'h00);
      grants = 0;
      n      = 0;
      while (grants < 4 && n < 80) begin
         step();
         n++;
         if (last_win >= 0) grants++;
      end
      chk("fairness_grants", grants, 4);
      hold_mask = 0;
      r_req[0]  = 1'b0;
      r_req[1]  = 1'b0;
      run_until_idle("fairness", 30);

      // Single op, rotates, illegal opcode.
      set_req(0, OP_POPCOUNT, 8'hF0, 8'h00);
      run_until_idle("single", 30);
      set_req(2, OP_ROTR, 8'h81, 8'h01);
      run_until_idle("rotr", 30);
      set_req(2, OP_ROTL, 8'h81, 8'h01);
      run_until_idle("rotl", 30);
      set_req(1, 3'b101, 8'h55, 8'h01);
      run_until_idle("illegal", 30);

      // Reset during WAIT: in-flight op dropped, pointer back to 0.
      set_req(1, OP_POPCOUNT, 8'h0F, 8'h00);
      n = 0;
      do begin
         step();
         n++;
      end while (last_win < 0 && n < 20);
      chk("rst_test_grant", last_win, 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wait_busy", 32'(busy), 32'd0);
      chk("rst_wait_alu_opcode", 32'(alu_opcode), 32'(OP_NOP));
      chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
      set_req(3, OP_PARITY, 8'h07, 8'h00);
      set_req(1, OP_ROTL,   8'hC3, 8'h04);
      run_until_idle("after_reset", 40);

      // Randomized traffic with immediate re-requests and withdrawals.
      for (int t = 0; t < 400; t++) begin
         step();
         for (int i = 0; i < NR; i++) begin
            if (i == last_win) begin
               if ($urandom_range(0, 1) == 1) new_rand_req(i);
            end else if (!r_req[i]) begin
               if ($urandom_range(0, 3) == 0) new_rand_req(i);
            end else if ($urandom_range(0, 15) == 0) begin
               r_req[i] = 1'b0;
            end
         end
      end
      for (int i = 0; i < NR; i++) r_req[i] = 1'b0;
      run_until_idle("drain", 40);
      step();
      chk("gnt_queue_empty", gq.size(), 0);
      chk("rsp_queue_empty", rq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
